// File: rtl/led_chase_sequencer.sv
// Timed chase sequencer for the 3-to-8 LED decoder select: walks one lit LED
// across led1..led7 in up, down, ping-pong or hold patterns at a divided tick rate.
module led_chase_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [1:0] mode,
    output logic [2:0] q,
    output logic       busy,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       q_reg;
    logic             dir_reg;     // 0 = counting up, 1 = counting down (ping-pong only)
    logic [1:0]       mode_reg;
    logic             wrap_reg;
    logic             busy_reg;

    logic [2:0]       step_q_next;
    logic             step_dir_next;
    logic             step_wrap_next;

    // Next LED position if a tick were taken this cycle.
    always_comb begin
        step_q_next    = q_reg;
        step_dir_next  = dir_reg;
        step_wrap_next = 1'b0;
        case (mode_reg)
            MODE_UP: begin
                if (q_reg == 3'd7) begin
                    step_q_next    = 3'd1;
                    step_wrap_next = 1'b1;
                end else begin
                    step_q_next = q_reg + 3'd1;
                end
            end
            MODE_DOWN: begin
                if (q_reg == 3'd1) begin
                    step_q_next    = 3'd7;
                    step_wrap_next = 1'b1;
                end else begin
                    step_q_next = q_reg - 3'd1;
                end
            end
            MODE_PING: begin
                if (!dir_reg) begin
                    if (q_reg == 3'd7) begin
                        step_q_next   = 3'd6;
                        step_dir_next = 1'b1;
                    end else begin
                        step_q_next = q_reg + 3'd1;
                    end
                end else begin
                    if (q_reg == 3'd1) begin
                        step_q_next    = 3'd2;
                        step_dir_next  = 1'b0;
                        step_wrap_next = 1'b1;
                    end else begin
                        step_q_next = q_reg - 3'd1;
                    end
                end
            end
            default: begin
                step_wrap_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            q_reg     <= 3'd0;
            dir_reg   <= 1'b0;
            mode_reg  <= MODE_UP;
            wrap_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop && !pause) begin
                        state_reg <= RUN;
                        mode_reg  <= mode;
                        cnt_reg   <= '0;
                        q_reg     <= (mode == MODE_DOWN) ? 3'd7 : 3'd1;
                        dir_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        q_reg     <= 3'd0;
                        dir_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (pause) begin
                        // Entering pause suppresses any step due on this edge.
                        state_reg <= PAUSE;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg  <= '0;
                        q_reg    <= step_q_next;
                        dir_reg  <= step_dir_next;
                        wrap_reg <= step_wrap_next;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        q_reg     <= 3'd0;
                        dir_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (start && !pause) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    q_reg     <= 3'd0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_reg;
    assign busy = busy_reg;
    assign wrap = wrap_reg;

endmodule
